// File: rtl/frame_buffer_multi_if.sv
// Camera-write / display-read bundle for frame_buffer_multi.
// master = camera + display side, slave = the frame buffer itself.
interface frame_buffer_multi_if #(
  parameter int DATA_W = 16,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240
);
  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = $clog2(V_RES);

  logic [DATA_W-1:0] w_data;
  logic              w_en;
  logic              vsync;
  logic              r_en;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              d_available;
  logic              frame_done;
  logic              overflow;

  modport master (
    output w_data, w_en, vsync, r_en, r_x, r_y,
    input  r_data, r_valid, d_available, frame_done, overflow
  );

  modport slave (
    input  w_data, w_en, vsync, r_en, r_x, r_y,
    output r_data, r_valid, d_available, frame_done, overflow
  );
endinterface

// File: rtl/frame_buffer_multi.sv
// Full-frame pixel store: sequential camera writes framed by vsync, random (x,y) display reads.
// Define FRAME_DOUBLE_BUFFER_EN for ping-pong banks that only ever show the last complete frame.
module frame_buffer_multi #(
  parameter int DATA_W = 16,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input logic                 clk,
  input logic                 rst,
  frame_buffer_multi_if.slave bus
);

  localparam int DEPTH = H_RES * V_RES;
  localparam int PW    = ADDR_W + 1;
`ifdef FRAME_DOUBLE_BUFFER_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int MEM_WORDS = NBANK * DEPTH;
  localparam int MA_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] DEPTH_M1 = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);

  // IDLE: no frame open (after reset), writes are silently dropped until vsync falls.
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_FULL} wr_state_t;

  wr_state_t         state, state_nxt;
  logic              w_en_q, r_en_q, vsync_q;
  logic              w_rise, r_rise, vs_fall, vs_rise;
  logic [PW-1:0]     wp, wp_nxt, wr_idx, rd_ri;
  logic [MA_W-1:0]   wr_phys, rd_phys;
  logic              mem_we, ovf_set, fd_nxt, avail_nxt;
  logic              x_ok, y_ok, in_range;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_en_q  <= 1'b0;
      r_en_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      w_en_q  <= bus.w_en;
      r_en_q  <= bus.r_en;
      vsync_q <= bus.vsync;
    end
  end

  assign w_rise  =  bus.w_en  & ~w_en_q;
  assign r_rise  =  bus.r_en  & ~r_en_q;
  assign vs_fall = ~bus.vsync &  vsync_q;
  assign vs_rise =  bus.vsync & ~vsync_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_fall)
      state_nxt = (w_rise && DEPTH == 1) ? ST_FULL : ST_FILL;
    else if (state == ST_FILL && w_rise && wp == DEPTH_M1)
      state_nxt = ST_FULL;
  end

  // A write coinciding with the frame start lands at index 0.
  always_comb begin
    mem_we  = 1'b0;
    ovf_set = 1'b0;
    wp_nxt  = wp;
    if (vs_fall) begin
      wp_nxt = '0;
      if (w_rise) begin
        mem_we = 1'b1;
        wp_nxt = ONE_P;
      end
    end else if (w_rise) begin
      case (state)
        ST_FILL: begin
          mem_we = 1'b1;
          wp_nxt = wp + ONE_P;
        end
        ST_FULL: ovf_set = 1'b1;
        default: ;
      endcase
    end
  end

  assign wr_idx = vs_fall ? '0 : wp;
  assign fd_nxt = vs_rise & (wp == DEPTH_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      bus.overflow <= 1'b0;
    end else begin
      wp <= wp_nxt;
      if (ovf_set) bus.overflow <= 1'b1;
    end
  end

  assign x_ok     = 32'(bus.r_x) < 32'(H_RES);
  assign y_ok     = 32'(bus.r_y) < 32'(V_RES);
  assign in_range = x_ok & y_ok;
  assign rd_ri    = PW'(bus.r_y) * PW'(H_RES) + PW'(bus.r_x);

`ifdef FRAME_DOUBLE_BUFFER_EN
  logic bank_sel;
  logic front_valid;

  // bank_sel names the front (display) bank; the camera always fills the other one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      front_valid <= 1'b0;
    end else if (fd_nxt) begin
      bank_sel    <= ~bank_sel;
      front_valid <= 1'b1;
    end
  end

  assign wr_phys   = MA_W'(wr_idx + (bank_sel ? '0 : DEPTH_P));
  assign rd_phys   = MA_W'(rd_ri + (bank_sel ? DEPTH_P : '0));
  assign avail_nxt = in_range & front_valid;
`else
  assign wr_phys   = MA_W'(wr_idx);
  assign rd_phys   = MA_W'(rd_ri);
  assign avail_nxt = in_range & (rd_ri < wp);
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_phys] <= bus.w_data;
  end

  // Nonblocking memory update gives read-before-write on a same-index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r_data      <= '0;
      bus.r_valid     <= 1'b0;
      bus.d_available <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.r_valid     <= r_rise;
      bus.frame_done  <= fd_nxt;
      bus.d_available <= avail_nxt;
      if (r_rise) bus.r_data <= in_range ? mem[rd_phys] : '0;
    end
  end

endmodule
